instr_prefetch: RTL

//  Instruction fetch stage placed directly upstream of the OSECPU decode/execute core.

---
 rtl/osecpu_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/instr_prefetch.sv | 106 ++++++++++
 3 files changed

// File: rtl/osecpu_pkg.sv
// ---------------------------------------------------------------------------
// osecpu_pkg
//   Definitions shared by the OSECPU front end and core.
//   - AW_DEFAULT / DW_DEFAULT : default address (word-addressed PC) and
//                               instruction widths
//   - RESET_PC_DEFAULT        : first fetch address after reset
//   - OP_END                  : opcode of the END instruction; the core
//                               decodes it and raises halt to the fetch stage
//   - fetch_entry_t           : one buffered fetch entry {pc, word}
// ---------------------------------------------------------------------------
package osecpu_pkg;

    localparam int AW_DEFAULT = 16;
    localparam int DW_DEFAULT = 32;

    localparam logic [AW_DEFAULT-1:0] RESET_PC_DEFAULT = 16'h0000;

    localparam logic [7:0] OP_END = 8'hF0;

    typedef struct packed {
        logic [AW_DEFAULT-1:0] pc;
        logic [DW_DEFAULT-1:0] word;
    } fetch_entry_t;

    // Sequential fetch address; wraps naturally from all-ones to zero.
    function automatic logic [AW_DEFAULT-1:0] next_pc(input logic [AW_DEFAULT-1:0] pc);
        return pc + AW_DEFAULT'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO holding fetched {pc, word} entries.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset (clears FIFO)
//     push, din    : write din at the tail
//     pop          : drop the head entry
//     flush        : discard every entry; takes priority over push and pop
//     dout         : head entry, forced to zero while the FIFO is empty
//     count        : current number of entries (0..DEPTH)
//   Pointers carry one extra wrap bit so full (count==DEPTH) and empty
//   (count==0) are distinguished by a plain subtraction.
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [W-1:0] store [DEPTH];
    logic         full;
    logic         is_empty;
    logic         do_push;
    logic         do_pop;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (PW+1)'(DEPTH));
    assign is_empty = (count == '0);

    // Defensive qualification: a push into a full FIFO is dropped unless a
    // pop frees a slot in the same cycle, and a pop on empty is ignored.
    assign do_pop  = pop & ~is_empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: an entry is only visible once written.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            store[wr_ptr[PW-1:0]] <= din;
        end
    end

    // Head entry reads as zero while empty so downstream sees clean values.
    assign dout = is_empty ? '0 : store[rd_ptr[PW-1:0]];

endmodule

// File: rtl/instr_prefetch.sv
// ---------------------------------------------------------------------------
// instr_prefetch
//   Instruction fetch stage in front of the OSECPU decode/execute core.
//   Issues reads to a synchronous memory (data returns one cycle after the
//   read strobe), buffers each returned word with its PC in fetch_fifo and
//   offers the head entry to decode.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     mem_addr, mem_re           : read address (= fetch_pc) and strobe
//     mem_rdata                  : read data, valid the cycle after mem_re
//     instr, instr_pc            : head-of-FIFO word and its fetch address
//     instr_valid, instr_ready   : decode handshake
//     redirect, redirect_pc      : flush and restart fetch at redirect_pc
//     halt                       : level; blocks new reads, FIFO still drains
//     empty                      : FIFO empty and no read in flight
//
//   Handshake: instr_valid is asserted whenever the FIFO holds an entry and
//   does not depend on instr_ready; instr/instr_pc hold steady while
//   instr_valid=1 and instr_ready=0. The head entry is consumed on every
//   cycle where instr_valid & instr_ready are both 1.
// ---------------------------------------------------------------------------
module instr_prefetch
    import osecpu_pkg::*;
#(
    parameter int           DEPTH    = 4,
    parameter int           AW       = AW_DEFAULT,
    parameter int           DW       = DW_DEFAULT,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic          empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [AW-1:0]    fetch_pc;
    logic [AW-1:0]    resp_pc;
    logic             resp_pend;
    logic [CW-1:0]    count;
    logic [CW:0]      credit_used;
    logic             push;
    logic             pop;
    logic [AW+DW-1:0] fifo_din;
    logic [AW+DW-1:0] fifo_dout;

    // A read is only issued when the FIFO is guaranteed room for its
    // response: entries already held plus the one still in flight.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, resp_pend};
    assign mem_re      = ~reset & ~halt & ~redirect & (credit_used < DEPTH_C);
    assign mem_addr    = fetch_pc;

    // A response arriving in a redirect cycle belongs to the old stream and
    // is dropped; the FIFO flush clears everything already buffered.
    assign push     = resp_pend & ~redirect;
    assign pop      = instr_valid & instr_ready;
    assign fifo_din = {resp_pc, mem_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            resp_pend <= 1'b0;
            resp_pc   <= '0;
        end else if (redirect) begin
            fetch_pc  <= redirect_pc;
            resp_pend <= 1'b0;
        end else begin
            resp_pend <= mem_re;
            resp_pc   <= fetch_pc;
            if (mem_re) begin
                fetch_pc <= fetch_pc + AW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (count)
    );

    assign instr_pc    = fifo_dout[AW+DW-1:DW];
    assign instr       = fifo_dout[DW-1:0];
    assign instr_valid = (count != '0);
    assign empty       = (count == '0) & ~resp_pend;

endmodule
